rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//   Shares the single write port of reg_file between NUM_REQ writeback sources (ALU, load unit, ...).
//   Round-robin arbitration with per-requester valid/ready handshake; drives rd_addr/rd_data/rd_en.
//   Sits between execute/memory writeback stages and the register file write port.
// PARAMETERS
//   NUM_REQ    4   number of writeback requesters (>=2)
//   NUM_REG    8   registers in the target reg_file (address width = $clog2(NUM_REG))
//   REG_WIDTH  32  data width
//   ZERO_REG   1   1: address 0 is hard-wired zero, writes to it are accepted but suppressed
// PORTS
//   clk_i        in   1                  clock
//   rst_ni       in   1                  reset, synchronous, active-low
//   rf_hold_i    in   1                  freeze arbitration (no grants while high)
//   req_valid_i  in   NUM_REQ            requester has a write pending
//   req_ready_o  out  NUM_REQ            one-hot grant; transfer on valid&&ready
//   req_addr_i   in   NUM_REQ x AW       destination register per requester
//   req_data_i   in   NUM_REQ x REG_WIDTH  write data per requester
//   rd_en_o      out  1                  reg_file write enable
//   rd_addr_o    out  AW                 reg_file write address
//   rd_data_o    out  REG_WIDTH          reg_file write data
//   grant_id_o   out  $clog2(NUM_REQ)    index of last granted requester
//   coll_cnt_o   out  16                 saturating count of cycles with >1 valid request
// BEHAVIOUR
//   - Reset (rst_ni=0 sampled at posedge): ptr=0, grant_id_o=0, coll_cnt_o=0, rd_en_o=0,
//     rd_addr_o=0, rd_data_o=0. While rst_ni=0: req_ready_o=0, rd_en_o=0 (also in comb mode).
//   - Arbiter: winner g = first i with req_valid_i[i], searching ptr, ptr+1, ... wrapping mod NUM_REQ.
//   - req_ready_o[g]=1 combinationally, all others 0; at most one bit set; none if no valid.
//   - On grant: ptr <= (g+1) mod NUM_REQ, grant_id_o <= g. No grant: ptr, grant_id_o unchanged.
//   - rf_hold_i=1: req_ready_o=0, rd_en_o=0 for that cycle, ptr unchanged; coll_cnt_o still counts.
//   - Requesters must hold valid/addr/data stable until ready; arbiter never drops a pending request.
//   - Zero register: ZERO_REG=1 and winner addr==0 -> ready asserted (request retired), rd_en_o=0.
//   - Write enable: rd_en_o=1 exactly for one transfer per grant with non-suppressed address.
//   - coll_cnt_o: +1 per cycle with popcount(req_valid_i)>=2 (hold or not); saturates at 16'hFFFF.
//   - Fairness: with all requesters valid, each granted exactly once every NUM_REQ grants.
//   - Addresses >= NUM_REG are passed through unmodified (reg_file ignores/aliases them).
// CONFIGURATION
//   WB_ARB_OUT_REG_EN defined: rd_en_o/rd_addr_o/rd_data_o registered; write reaches reg_file
//     one cycle after the handshake cycle; outputs reset to 0.
//   WB_ARB_OUT_REG_EN undefined: rd_* driven combinationally from winner in the handshake cycle
//     (zero latency); rd_addr_o/rd_data_o = 0 when no grant.
// TESTING (run with and without WB_ARB_OUT_REG_EN; reg_file instantiated as write target)
//   1. Only req0 valid, addr 3, data 0xDEADBEEF -> ready0=1 same cycle; rd_en_o=1 addr 3 (+1 cycle
//      if OUT_REG); reg_file read of R3 returns 0xDEADBEEF.
//   2. After reset all 4 valid continuously -> grant order 0,1,2,3,0,1...; coll_cnt_o +1 per cycle.
//   3. ptr=2 (after granting req1), req1 & req3 valid -> grant 3 first, then 1.
//   4. req2 addr 0 data 0x55 (ZERO_REG=1) -> ready2=1, rd_en_o=0; R0 reads 0x00000000.
//   5. All valid, rf_hold_i=1 for 5 cycles -> no ready, no rd_en, ptr frozen, coll_cnt_o +5;
//      release -> grants resume from frozen ptr.
//   6. rst_ni low mid-stream (OUT_REG, grant pending) -> next edge rd_en_o=0, ptr=0, coll_cnt_o=0;
//      held requests granted from req0 after release. Also force coll_cnt_o saturation at 0xFFFF.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//   Shares the single write port of the register file between NUM_REQ
//   writeback sources (ALU, load unit, ...). A round-robin arbiter picks one
//   pending requester per cycle and forwards its address/data to the
//   register file write port.
//
// Optional feature macro: WB_ARB_OUT_REG_EN
//   defined   : rd_en_o/rd_addr_o/rd_data_o are registered, so the write
//               reaches the register file one cycle after the handshake.
//   undefined : rd_* are driven combinationally from the winner in the
//               handshake cycle (zero latency); addr/data read 0 when idle.
//
// Handshake: a requester raises req_valid_i[i] and holds valid/addr/data
//   stable until it sees req_ready_o[i]. A transfer happens in every cycle
//   where req_valid_i[i] && req_ready_o[i]. Ready is a one-hot grant and
//   never asserts without valid.
//
// Ports
//   clk_i        clock
//   rst_ni       synchronous active-low reset
//   rf_hold_i    freeze arbitration (no grants while high)
//   req_valid_i  per-requester write pending
//   req_ready_o  one-hot grant
//   req_addr_i   per-requester destination register
//   req_data_i   per-requester write data
//   rd_en_o      register file write enable
//   rd_addr_o    register file write address
//   rd_data_o    register file write data
//   grant_id_o   index of last granted requester
//   coll_cnt_o   saturating count of cycles with more than one valid request
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_REG   = 8,
  parameter int REG_WIDTH = 32,
  parameter int ZERO_REG  = 1,
  localparam int AW = (NUM_REG > 1) ? $clog2(NUM_REG) : 1,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                rf_hold_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ-1:0][AW-1:0]          req_addr_i,
  input  logic [NUM_REQ-1:0][REG_WIDTH-1:0]   req_data_i,
  output logic                                rd_en_o,
  output logic [AW-1:0]                       rd_addr_o,
  output logic [REG_WIDTH-1:0]                rd_data_o,
  output logic [IW-1:0]                       grant_id_o,
  output logic [15:0]                         coll_cnt_o
);

  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        gid_q, gid_d;
  logic [15:0]          coll_q, coll_d;

  logic                 found;
  logic [IW-1:0]        win;
  logic                 multi;
  logic                 grant;
  logic                 suppress;
  logic                 wr_en;
  logic [AW-1:0]        win_addr;
  logic [REG_WIDTH-1:0] win_data;

  // Round-robin search starting at ptr_q, wrapping modulo NUM_REQ.
  always_comb begin : arb_search
    logic [IW-1:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // More than one valid request this cycle (independent of hold/reset gating).
  always_comb begin : multi_detect
    logic seen;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid_i[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
  end

  assign win_addr = req_addr_i[win];
  assign win_data = req_data_i[win];

  // Grants are withheld while in reset or while the register file is held.
  assign grant    = found && rst_ni && !rf_hold_i;
  // Writes to the hard-wired zero register are retired but never written.
  assign suppress = (ZERO_REG != 0) && (win_addr == '0);
  assign wr_en    = grant && !suppress;

  always_comb begin
    req_ready_o = '0;
    if (grant) req_ready_o[win] = 1'b1;
  end

  always_comb begin
    ptr_d  = ptr_q;
    gid_d  = gid_q;
    coll_d = coll_q;
    if (grant) begin
      ptr_d = IW'((int'(win) + 1) % NUM_REQ);
      gid_d = win;
    end
    if (multi && (coll_q != 16'hFFFF)) coll_d = coll_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q  <= '0;
      gid_q  <= '0;
      coll_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      gid_q  <= gid_d;
      coll_q <= coll_d;
    end
  end

  assign grant_id_o = gid_q;
  assign coll_cnt_o = coll_q;

`ifdef WB_ARB_OUT_REG_EN
  logic                 rd_en_q,   rd_en_d;
  logic [AW-1:0]        rd_addr_q, rd_addr_d;
  logic [REG_WIDTH-1:0] rd_data_q, rd_data_d;

  assign rd_en_d   = wr_en;
  assign rd_addr_d = grant ? win_addr : '0;
  assign rd_data_d = grant ? win_data : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // A write captured just before reset asserts must not reach the register
  // file while reset is low, so the enable is gated before the clearing edge.
  assign rd_en_o   = rd_en_q && rst_ni;
  assign rd_addr_o = rd_addr_q;
  assign rd_data_o = rd_data_q;
`else
  assign rd_en_o   = wr_en;
  assign rd_addr_o = grant ? win_addr : '0;
  assign rd_data_o = grant ? win_data : '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
//   Directed bench for rf_wb_arbiter. A small register file array is written
//   from rd_* so writes can be read back. Each tick samples the DUT on the
//   falling edge against a round-robin reference model and a queue of
//   expected register-file writes, then advances one clock. Works with and
//   without WB_ARB_OUT_REG_EN.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int NUM_REG   = 8;
  localparam int REG_WIDTH = 32;
  localparam int AW        = 3;
  localparam int IW        = 2;
  localparam int EW        = AW + REG_WIDTH;
`ifdef WB_ARB_OUT_REG_EN
  localparam bit OUT_REG = 1'b1;
`else
  localparam bit OUT_REG = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                              hold;
  logic [NUM_REQ-1:0]                valid;
  logic [NUM_REQ-1:0]                ready;
  logic [NUM_REQ-1:0][AW-1:0]        addr;
  logic [NUM_REQ-1:0][REG_WIDTH-1:0] data;
  logic                              rd_en;
  logic [AW-1:0]                     rd_addr;
  logic [REG_WIDTH-1:0]              rd_data;
  logic [IW-1:0]                     gid;
  logic [15:0]                       coll;

  rf_wb_arbiter #(
    .NUM_REQ(NUM_REQ), .NUM_REG(NUM_REG), .REG_WIDTH(REG_WIDTH), .ZERO_REG(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .rf_hold_i(hold),
    .req_valid_i(valid), .req_ready_o(ready),
    .req_addr_i(addr), .req_data_i(data),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_o(rd_data),
    .grant_id_o(gid), .coll_cnt_o(coll)
  );

  // Register file write target.
  logic [REG_WIDTH-1:0] rf [NUM_REG];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REG; i++) rf[i] <= '0;
    end else if (rd_en) begin
      rf[rd_addr] <= rd_data;
    end
  end

  // ---------------- scoreboard / model state ----------------
  logic [EW-1:0] exp_q[$];
  int            gnt_log[$];
  int            m_ptr, m_gid, m_coll;
  bit            stream;
  int            n_checks, n_pass;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: compare on the falling edge, update the model for the coming
  // rising edge, then let granted requesters retire or present new work.
  task automatic tick();
    logic [NUM_REQ-1:0] e_rdy;
    logic [EW-1:0]      e;
    int                 g;
    int                 nv;
    @(negedge clk);
    e_rdy = '0;
    g     = -1;
    if (rst_n && !hold) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int i;
        i = (m_ptr + k) % NUM_REQ;
        if (g < 0 && valid[i]) g = i;
      end
    end
    if (g >= 0) e_rdy[g] = 1'b1;
    chk("ready", ready, e_rdy);
    chk("grant_id", gid, m_gid);
    chk("coll_cnt", coll, m_coll);

    if (!rst_n) exp_q.delete();
    if (!OUT_REG && g >= 0 && addr[g] != '0) exp_q.push_back({addr[g], data[g]});
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rd_en", rd_en, 1);
      chk("rd_addr", rd_addr, e[EW-1:REG_WIDTH]);
      chk("rd_data", rd_data, e[REG_WIDTH-1:0]);
    end else begin
      chk("rd_en_idle", rd_en, 0);
      if (rst_n) chk("rd_addr_idle", rd_addr, 0);
    end
    if (OUT_REG && g >= 0 && addr[g] != '0) exp_q.push_back({addr[g], data[g]});

    nv = 0;
    for (int i = 0; i < NUM_REQ; i++) if (valid[i]) nv++;
    if (!rst_n) begin
      m_ptr  = 0;
      m_gid  = 0;
      m_coll = 0;
    end else begin
      if (nv >= 2 && m_coll < 65535) m_coll++;
      if (g >= 0) begin
        m_ptr = (g + 1) % NUM_REQ;
        m_gid = g;
        gnt_log.push_back(g);
      end
    end

    @(posedge clk);
    #1;
    if (g >= 0) begin
      if (stream) begin
        addr[g] = AW'($urandom_range(0, NUM_REG - 1));
        data[g] = $urandom;
      end else begin
        valid[g] = 1'b0;
      end
    end
  endtask

  task automatic load_all();
    for (int i = 0; i < NUM_REQ; i++) begin
      addr[i]  = AW'($urandom_range(1, NUM_REG - 1));
      data[i]  = $urandom;
      valid[i] = 1'b1;
    end
  endtask

  int c0;
  int n0;

  initial begin
    n_checks = 0; n_pass = 0;
    m_ptr = 0; m_gid = 0; m_coll = 0; stream = 0;
    rst_n = 1'b0; hold = 1'b0; valid = '0; addr = '0; data = '0;

    // Reset state
    repeat (2) tick();
    chk("rst_grant_id", gid, 0);
    chk("rst_coll", coll, 0);
    chk("rst_rd_en", rd_en, 0);
    rst_n = 1'b1;
    tick();

    // Single requester, addr 3
    valid[0] = 1'b1; addr[0] = 3'd3; data[0] = 32'hDEADBEEF;
    gnt_log.delete();
    repeat (3) tick();
    chk("t1_grant", gnt_log[0], 0);
    chk("t1_R3", rf[3], 32'hDEADBEEF);

    // All valid after reset: strict rotation and collision counting
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    gnt_log.delete();
    c0 = coll;
    stream = 1; load_all();
    repeat (8) tick();
    for (int i = 0; i < 8; i++) chk("t2_order", gnt_log[i], i % NUM_REQ);
    chk("t2_coll", coll, c0 + 8);
    stream = 0;
    repeat (4) tick();

    // ptr=2 after granting req1; req1 & req3 -> 3 then 1
    valid[1] = 1'b1; addr[1] = 3'd5; data[1] = 32'h1111_0001;
    tick();
    valid[1] = 1'b1; addr[1] = 3'd6; data[1] = 32'h1111_0002;
    valid[3] = 1'b1; addr[3] = 3'd7; data[3] = 32'h3333_0003;
    gnt_log.delete();
    repeat (2) tick();
    chk("t3_first", gnt_log[0], 3);
    chk("t3_second", gnt_log[1], 1);
    tick();
    chk("t3_R6", rf[6], 32'h1111_0002);
    chk("t3_R7", rf[7], 32'h3333_0003);

    // Zero-register write is retired but suppressed
    valid[2] = 1'b1; addr[2] = 3'd0; data[2] = 32'h55;
    gnt_log.delete();
    repeat (2) tick();
    chk("t4_grant", gnt_log[0], 2);
    chk("t4_R0", rf[0], 0);

    // Hold for 5 cycles with all valid; ptr is 3 -> grant 3, then frozen at 0
    stream = 1; load_all();
    tick();
    hold = 1'b1;
    c0 = coll;
    n0 = gnt_log.size();
    repeat (5) tick();
    chk("t5_coll", coll, c0 + 5);
    chk("t5_no_grant", gnt_log.size(), n0);
    hold = 1'b0;
    tick();
    chk("t5_resume", gnt_log[$], 0);
    stream = 0;
    repeat (4) tick();

    // Reset mid-stream with a grant pending
    stream = 1; load_all();
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    chk("t6_coll", coll, 0);
    chk("t6_gid", gid, 0);
    chk("t6_rd_en", rd_en, 0);
    rst_n = 1'b1;
    gnt_log.delete();
    tick();
    chk("t6_first", gnt_log[0], 0);
    stream = 0;
    repeat (4) tick();

    // Collision counter saturation
    valid = 4'b0011; addr[0] = 3'd1; addr[1] = 3'd2;
    hold = 1'b1;
    repeat (65540) tick();
    chk("sat_coll", coll, 16'hFFFF);
    hold = 1'b0;
    repeat (3) tick();
    chk("sat_hold", coll, 16'hFFFF);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
